// File: rtl/demux_router.sv
// Registered 1-to-4 demultiplexer with valid/ready on every side.
// One-entry holding register per channel; explicit or round-robin steering.
module demux_router #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_rr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [1:0]        rr_ptr,
    output logic [CNT_W-1:0]  acc_cnt
);

    logic [DATA_W-1:0] dreg [4];
    logic [1:0]        tgt;
    logic              accept;
    logic [3:0]        load;
    logic [3:0]        drain;

    assign tgt      = in_rr ? rr_ptr : in_sel;
    assign in_ready = rst_n & (~out_valid[tgt] | out_ready[tgt]);
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            rr_ptr    <= '0;
            acc_cnt   <= '0;
            for (int k = 0; k < 4; k++) begin
                dreg[k] <= '0;
            end
        end else begin
            // a load into a draining channel keeps it full with the new word
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    dreg[k]      <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (drain[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
                if (in_rr) begin
                    rr_ptr <= rr_ptr + 2'd1;
                end
            end
        end
    end

    assign out_data0 = dreg[0];
    assign out_data1 = dreg[1];
    assign out_data2 = dreg[2];
    assign out_data3 = dreg[3];

endmodule
